// File: rtl/uart_pkg.sv
// Shared types and the baud divisor helper for the UART receive controller.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        RXC_IDLE  = 2'd0,
        RXC_CLEAR = 2'd1,
        RXC_WAIT  = 2'd2
    } rx_ctrl_state_t;

    // Rounded 16x-oversampling divisor: round(clk_hz / (baud * 16)).
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud * 8) / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks (16x baud enable).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 27
) (
    input  logic clk_50m,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] divider;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            divider <= '0;
        end else if (divider == LAST) begin
            divider <= '0;
        end else begin
            divider <= divider + W'(1);
        end
    end

    // Decoded from the counter so the tick is exactly one cycle wide.
    assign tick = (divider == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: baud tick, byte capture/acknowledge FSM and FWFT byte FIFO.
// Optional dropped-byte counter enabled by defining UART_RX_CTRL_OVR_CNT_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_50m,
    input  logic                          rst,
    output logic                          rx_clken,
    input  logic                          rx_ready,
    input  logic [7:0]                    rx_data,
    output logic                          rx_ready_clr,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    input  logic                          rd_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          overrun_clr,
`ifdef UART_RX_CTRL_OVR_CNT_EN
    output logic [7:0]                    ovr_count,
`endif
    output logic [1:0]                    ctrl_state
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = RXC_IDLE;
    localparam logic [1:0] ST_CLEAR = RXC_CLEAR;
    localparam logic [1:0] ST_WAIT  = RXC_WAIT;

    uart_baud_gen #(.DIV(DIV)) u_baud_gen (
        .clk_50m (clk_50m),
        .rst     (rst),
        .tick    (rx_clken)
    );

    // ---------------- capture / acknowledge FSM ----------------
    logic [1:0] fsm_state;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            fsm_state <= ST_IDLE;
        end else begin
            case (fsm_state)
                ST_IDLE:  if (rx_ready) fsm_state <= ST_CLEAR;
                ST_CLEAR: fsm_state <= ST_WAIT;
                ST_WAIT:  if (!rx_ready) fsm_state <= ST_IDLE;
                default:  fsm_state <= ST_IDLE;
            endcase
        end
    end

    // Waiting for rx_ready to fall keeps a still-held flag from pushing the same byte twice.
    assign rx_ready_clr = (fsm_state != ST_CLEAR);
    assign ctrl_state   = fsm_state;

    // ---------------- FWFT byte FIFO ----------------
    // Read handshake: rd_data is valid whenever rd_valid=1; a pop occurs on a clock edge
    // where rd_valid=1 and rd_en=1. rd_en while rd_valid=0 has no effect.
    uart_byte_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_req;
    logic          push_ok;
    logic          pop_ok;
    logic          refused;

    assign push_req = (fsm_state == ST_IDLE) && rx_ready;
    assign pop_ok   = rd_en && (count != '0);
    // A full FIFO still accepts when the same edge frees a slot.
    assign push_ok  = push_req && ((count != FULL) || pop_ok);
    assign refused  = push_req && !push_ok;

    always_ff @(posedge clk_50m) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_valid   = (count != '0);
    assign rd_data    = mem[rd_ptr];
    assign fifo_count = count;

    // ---------------- overrun reporting ----------------
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (refused) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_CTRL_OVR_CNT_EN
    logic [7:0] ovr_cnt;

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            ovr_cnt <= 8'd0;
        end else if (refused && overrun_clr) begin
            ovr_cnt <= 8'd1;
        end else if (refused) begin
            if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
        end else if (overrun_clr) begin
            ovr_cnt <= 8'd0;
        end
    end

    assign ovr_count = ovr_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: tick timing, ack handshake, FIFO order, overrun, reset.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;

    logic       clk_50m;
    logic       rst;
    logic       rx_clken;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_ready_clr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_en;
    logic [3:0] fifo_count;
    logic       overrun;
    logic       overrun_clr;
    logic [7:0] ovr_count;
    logic [1:0] ctrl_state;

    uart_rx_ctrl #(
        .CLK_HZ     (50_000_000),
        .BAUD       (115200),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .rx_clken     (rx_clken),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_ready_clr (rx_ready_clr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .fifo_count   (fifo_count),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
`ifdef UART_RX_CTRL_OVR_CNT_EN
        .ovr_count    (ovr_count),
`endif
        .ctrl_state   (ctrl_state)
    );

    // ---------------- clock / reset ----------------
    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         mcnt;
    logic       exp_ovr;
    int         exp_ocnt;
    int         n_checks;
    int         n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a posedge; returns just after a posedge.
    task automatic send_byte(input logic [7:0] b, input int hold, input bit with_pop);
        int         acks;
        bit         seen;
        int         waited;
        logic [7:0] head;
        acks = 0; seen = 1'b0; waited = 0;
        rx_ready = 1'b1;
        rx_data  = b;
        rd_en    = with_pop;
        if (with_pop) begin
            @(negedge clk_50m);
            check("pop_valid", rd_valid, 1);
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                head = exp_q.pop_front();
                check("pop_data", rd_data, head);
            end
            exp_q.push_back(b);
            @(posedge clk_50m); #1;
            rd_en = 1'b0;
        end else if (mcnt < DEPTH) begin
            exp_q.push_back(b);
            mcnt++;
        end else begin
            exp_ovr = 1'b1;
            if (exp_ocnt < 255) exp_ocnt++;
        end
        while (!seen && waited < 50) begin
            @(negedge clk_50m);
            if (!rx_ready_clr) begin
                acks++;
                seen = 1'b1;
            end
            @(posedge clk_50m); #1;
            waited++;
        end
        if (!seen) check("ack_timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_50m);
            if (!rx_ready_clr) acks++;
            check("hold_wait", ctrl_state, 2);
            check("hold_count", fifo_count, mcnt);
            @(posedge clk_50m); #1;
        end
        rx_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_50m);
            if (!rx_ready_clr) acks++;
            @(posedge clk_50m); #1;
        end
        @(negedge clk_50m);
        check("ack_once", acks, 1);
        check("back_idle", ctrl_state, 0);
        check("count", fifo_count, mcnt);
        @(posedge clk_50m); #1;
    endtask

    task automatic pop_byte();
        logic [7:0] head;
        rd_en = 1'b1;
        @(negedge clk_50m);
        check("rd_valid", rd_valid, 1);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            head = exp_q.pop_front();
            check("rd_data", rd_data, head);
        end
        @(posedge clk_50m); #1;
        rd_en = 1'b0;
        if (mcnt > 0) mcnt--;
    endtask

    task automatic clear_overrun();
        overrun_clr = 1'b1;
        @(posedge clk_50m); #1;
        overrun_clr = 1'b0;
        exp_ovr  = 1'b0;
        exp_ocnt = 0;
        @(negedge clk_50m);
        check("ovr_cleared", overrun, exp_ovr);
`ifdef UART_RX_CTRL_OVR_CNT_EN
        check("ovr_count_cleared", ovr_count, exp_ocnt);
`endif
        @(posedge clk_50m); #1;
    endtask

    // ---------------- stimulus ----------------
    int first_tick;
    int last_tick;
    int n_ticks;
    int bad_gap;
    int wide;
    bit prev_tick;
    bit seen_ack;

    initial begin
        n_checks = 0; n_errors = 0;
        mcnt = 0; exp_ovr = 1'b0; exp_ocnt = 0;
        rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; rd_en = 1'b0; overrun_clr = 1'b0;
        ovr_count = 8'h00;
        repeat (3) @(posedge clk_50m);
        #1 rst = 1'b0;

        // Reset values, then tick cadence over 200 cycles.
        @(negedge clk_50m);
        check("rst_clken", rx_clken, 0);
        check("rst_ready_clr", rx_ready_clr, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", ctrl_state, 0);
        first_tick = -1; last_tick = -1; n_ticks = 0; bad_gap = 0; wide = 0; prev_tick = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk_50m);
            if (rx_clken) begin
                if (prev_tick) wide++;
                if (first_tick < 0) first_tick = k;
                else if (k - last_tick != 27) bad_gap++;
                last_tick = k;
                n_ticks++;
            end
            prev_tick = rx_clken;
        end
        check("tick_first", first_tick, 26);
        check("tick_num", n_ticks, 7);
        check("tick_gap", bad_gap, 0);
        check("tick_wide", wide, 0);
        @(posedge clk_50m); #1;

        // Single byte capture.
        send_byte(8'hA5, 0, 1'b0);
        @(negedge clk_50m);
        check("one_valid", rd_valid, 1);
        check("one_data", rd_data, 8'hA5);
        check("one_count", fifo_count, 1);
        @(posedge clk_50m); #1;
        pop_byte();

        // Receiver holds rx_ready long after the ack: no duplicate push.
        send_byte(8'h3C, 10, 1'b0);
        pop_byte();

        // Fill to full, then one refused byte.
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0, 1'b0);
        send_byte(8'hFF, 0, 1'b0);
        @(negedge clk_50m);
        check("full_count", fifo_count, DEPTH);
        check("full_overrun", overrun, exp_ovr);
`ifdef UART_RX_CTRL_OVR_CNT_EN
        check("full_ovr_count", ovr_count, exp_ocnt);
`endif
        @(posedge clk_50m); #1;
        for (int i = 0; i < DEPTH; i++) pop_byte();

        // Push into a full FIFO on the same edge as a pop.
        clear_overrun();
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 0, 1'b0);
        send_byte(8'h55, 0, 1'b1);
        @(negedge clk_50m);
        check("swap_count", fifo_count, DEPTH);
        check("swap_overrun", overrun, 0);
        @(posedge clk_50m); #1;
        for (int i = 0; i < DEPTH; i++) pop_byte();

        // Reset while in CLEAR with bytes queued.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 0, 1'b0);
        rx_ready = 1'b1;
        rx_data  = 8'h99;
        seen_ack = 1'b0;
        for (int i = 0; i < 50 && !seen_ack; i++) begin
            @(negedge clk_50m);
            if (!rx_ready_clr) seen_ack = 1'b1;
            else begin
                @(posedge clk_50m); #1;
            end
        end
        check("mid_ack_seen", seen_ack, 1);
        rst = 1'b1;
        rx_ready = 1'b0;
        @(posedge clk_50m); #1;
        exp_q.delete();
        mcnt = 0; exp_ovr = 1'b0; exp_ocnt = 0;
        @(negedge clk_50m);
        check("mid_rst_ready_clr", rx_ready_clr, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_state", ctrl_state, 0);
        @(posedge clk_50m); #1;
        rst = 1'b0;

        // Normal operation resumes after reset.
        send_byte(8'hC3, 0, 1'b0);
        pop_byte();
        @(negedge clk_50m);
        check("end_count", fifo_count, 0);
        check("end_rd_valid", rd_valid, 0);
        check("end_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
